display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux_if.sv | 24 ++
 rtl/display_scan_mux.sv | 125 ++++++++++++
 tb/tb_display_scan_mux.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
// Bus bundle for the multiplexed display scanner.
// master: the side that supplies the display word and reads back the scan
// outputs; slave: the scanner itself.
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] inpreg;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [4:0]              Digit;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output inpreg, load, blank_mask,
        input  Digit, anode, pending, frame_done
    );

    modport slave (
        input  inpreg, load, blank_mask,
        output Digit, anode, pending, frame_done
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner for a NUM_DIGITS common-anode display.
// A prescaler divides clkin into digit slots. The index counter walks the
// digits, and a pending/shadow register pair makes new words take effect
// only on a frame boundary, so a frame is never drawn from two words.
// Optional feature: define LZ_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked). Without it, no leading-zero logic is built.
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000
) (
    input logic               clkin,
    input logic               reset,
    display_scan_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]         presc;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pend_word;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   anode_nxt;

    assign tick = (presc == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Slot prescaler: counts 0..PRESCALE-1 and restarts after the tick.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + PS_W'(1);
    end

    // Digit index: advances once per slot and wraps after the last digit.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)
            idx <= '0;
        else if (tick) begin
            if (idx == IDX_LAST)
                idx <= '0;
            else
                idx <= idx + IDX_W'(1);
        end
    end

    // Frame marker, one cycle after the wrapping tick.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)
            bus.frame_done <= 1'b0;
        else
            bus.frame_done <= wrap;
    end

    // Word capture: loads park in pend_word until the frame boundary; a load
    // landing exactly on the boundary skips the parking stage entirely.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            pend_word   <= '0;
            shadow      <= '0;
            bus.pending <= 1'b0;
        end else if (bus.load && wrap) begin
            shadow      <= bus.inpreg;
            bus.pending <= 1'b0;
        end else if (bus.load) begin
            pend_word   <= bus.inpreg;
            bus.pending <= 1'b1;
        end else if (wrap && bus.pending) begin
            shadow      <= pend_word;
            bus.pending <= 1'b0;
        end
    end

`ifdef LZ_BLANK_EN
    logic lz_run;

    // Leading-zero flags: a digit is blanked while it and every higher
    // digit hold zero; digit 0 always shows.
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run = lz_run && (shadow[4*k +: 4] == 4'h0);
            lz[k]  = lz_run;
        end
    end
`else
    // No leading-zero suppression in this build.
    always_comb lz = '0;
`endif

    // Select the nibble, blank term and anode pattern for the current index.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        anode_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib      = shadow[4*k +: 4];
                cur_blank    = bus.blank_mask[k] | lz[k];
                anode_nxt[k] = 1'b0;
            end
        end
    end

    // Registered digit drive; a blanked digit also forces its value to zero.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            bus.Digit <= 5'h10;
            bus.anode <= '1;
        end else begin
            bus.Digit <= cur_blank ? 5'h10 : {1'b0, cur_nib};
            bus.anode <= anode_nxt;
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, PRESCALE=4.
// c counts rising edges since the last reset release; the outputs sampled
// after edge c show slot ((c-1)/4)%4, and the frame wraps at edges 16, 32...
module tb_display_scan_mux;
    localparam int ND = 4;
    localparam int PS = 4;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   c = 0;

    display_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at c=%0d", c);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_anode(input int slot);
        logic [3:0] a;
        a       = 4'hF;
        a[slot] = 1'b0;
        return a;
    endfunction

    // Display of an all-zero shadow word.
    function automatic logic [4:0] idle_digit(input int slot);
`ifdef LZ_BLANK_EN
        return (slot == 0) ? 5'h00 : 5'h10;
`else
        return 5'h00;
`endif
    endfunction

    task automatic step();
        @(negedge clkin);
        c++;
    endtask

    task automatic test_reset();
        bus.inpreg     = '0;
        bus.load       = 1'b0;
        bus.blank_mask = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clkin);
        vectors++;
        if (bus.Digit !== 5'h10) begin
            miscompares++;
            $display("FAIL reset_digit got %h want 10", bus.Digit);
        end
        vectors++;
        if (bus.anode !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_anode got %b want 1111", bus.anode);
        end
        vectors++;
        if (bus.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending got %b want 0", bus.pending);
        end
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
        end
        reset = 1'b1;
        c = 0;
    endtask

    task automatic test_scan_idle();
        int slot;
        for (int i = 0; i < 32; i++) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.anode !== exp_anode(slot)) begin
                miscompares++;
                $display("FAIL idle_anode c=%0d got %b want %b", c, bus.anode, exp_anode(slot));
            end
            vectors++;
            if (bus.Digit !== idle_digit(slot)) begin
                miscompares++;
                $display("FAIL idle_digit c=%0d got %h want %h", c, bus.Digit, idle_digit(slot));
            end
            vectors++;
            if (bus.frame_done !== ((c % 16) == 0)) begin
                miscompares++;
                $display("FAIL idle_frame_done c=%0d got %b want %b", c, bus.frame_done, (c % 16) == 0);
            end
            vectors++;
            if (bus.pending !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_pending c=%0d got %b want 0", c, bus.pending);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [4:0] exp_d [4];
        int slot;
        exp_d[0] = 5'h03; exp_d[1] = 5'h0C; exp_d[2] = 5'h05; exp_d[3] = 5'h0A;
        repeat (4) step();
        bus.inpreg = 16'hA5C3;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        bus.inpreg = 16'h0000;
        vectors++;
        if (bus.pending !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pending_set c=%0d got %b want 1", c, bus.pending);
        end
        while (c < 48) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.pending !== (c < 48)) begin
                miscompares++;
                $display("FAIL mid_pending c=%0d got %b want %b", c, bus.pending, c < 48);
            end
            vectors++;
            if (bus.Digit !== idle_digit(slot)) begin
                miscompares++;
                $display("FAIL mid_old_frame c=%0d got %h want %h", c, bus.Digit, idle_digit(slot));
            end
            vectors++;
            if (bus.frame_done !== (c == 48)) begin
                miscompares++;
                $display("FAIL mid_frame_done c=%0d got %b want %b", c, bus.frame_done, c == 48);
            end
        end
        while (c < 64) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.Digit !== exp_d[slot]) begin
                miscompares++;
                $display("FAIL mid_new_frame c=%0d got %h want %h", c, bus.Digit, exp_d[slot]);
            end
            vectors++;
            if (bus.anode !== exp_anode(slot)) begin
                miscompares++;
                $display("FAIL mid_anode c=%0d got %b want %b", c, bus.anode, exp_anode(slot));
            end
        end
    endtask

    task automatic test_last_write_wins();
        int slot;
        repeat (4) step();
        bus.inpreg = 16'h1111;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        repeat (3) step();
        bus.inpreg = 16'h2222;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        bus.inpreg = 16'h0000;
        vectors++;
        if (bus.pending !== 1'b1) begin
            miscompares++;
            $display("FAIL lww_pending_second c=%0d got %b want 1", c, bus.pending);
        end
        while (c < 79) step();
        vectors++;
        if (bus.pending !== 1'b1) begin
            miscompares++;
            $display("FAIL lww_pending_hold c=%0d got %b want 1", c, bus.pending);
        end
        step();
        vectors++;
        if (bus.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL lww_pending_clear c=%0d got %b want 0", c, bus.pending);
        end
        while (c < 96) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.Digit !== 5'h02) begin
                miscompares++;
                $display("FAIL lww_digit c=%0d slot=%0d got %h want 02", c, slot, bus.Digit);
            end
        end
    endtask

    task automatic test_load_at_wrap();
        logic [4:0] exp_d [4];
        int slot;
`ifdef LZ_BLANK_EN
        exp_d[0] = 5'h00; exp_d[1] = 5'h0F; exp_d[2] = 5'h10; exp_d[3] = 5'h10;
`else
        exp_d[0] = 5'h00; exp_d[1] = 5'h0F; exp_d[2] = 5'h00; exp_d[3] = 5'h00;
`endif
        while (c < 111) step();
        bus.inpreg = 16'h00F0;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        bus.inpreg = 16'h0000;
        vectors++;
        if (bus.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pending c=%0d got %b want 0", c, bus.pending);
        end
        vectors++;
        if (bus.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_frame_done c=%0d got %b want 1", c, bus.frame_done);
        end
        while (c < 128) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.Digit !== exp_d[slot]) begin
                miscompares++;
                $display("FAIL wrap_digit c=%0d got %h want %h", c, bus.Digit, exp_d[slot]);
            end
            vectors++;
            if (bus.pending !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_pending_frame c=%0d got %b want 0", c, bus.pending);
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [4:0] exp_d [4];
        int slot;
`ifdef LZ_BLANK_EN
        exp_d[0] = 5'h00; exp_d[1] = 5'h0F; exp_d[2] = 5'h10; exp_d[3] = 5'h10;
`else
        exp_d[0] = 5'h00; exp_d[1] = 5'h0F; exp_d[2] = 5'h10; exp_d[3] = 5'h00;
`endif
        bus.blank_mask = 4'b0100;
        while (c < 144) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.Digit !== exp_d[slot]) begin
                miscompares++;
                $display("FAIL blank_digit c=%0d got %h want %h", c, bus.Digit, exp_d[slot]);
            end
            vectors++;
            if (bus.anode !== exp_anode(slot)) begin
                miscompares++;
                $display("FAIL blank_anode c=%0d got %b want %b", c, bus.anode, exp_anode(slot));
            end
        end
        bus.blank_mask = 4'b0000;
    endtask

    task automatic test_reset_midframe();
        int slot;
        step();
        bus.inpreg = 16'h4321;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        bus.inpreg = 16'h0000;
        vectors++;
        if (bus.pending !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pending_before c=%0d got %b want 1", c, bus.pending);
        end
        while (c < 154) step();
        vectors++;
        if (bus.anode !== 4'b1011) begin
            miscompares++;
            $display("FAIL rst_slot2_anode c=%0d got %b want 1011", c, bus.anode);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.Digit !== 5'h10) begin
            miscompares++;
            $display("FAIL rst_mid_digit got %h want 10", bus.Digit);
        end
        vectors++;
        if (bus.anode !== 4'hF) begin
            miscompares++;
            $display("FAIL rst_mid_anode got %b want 1111", bus.anode);
        end
        vectors++;
        if (bus.pending !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_pending got %b want 0", bus.pending);
        end
        repeat (2) @(negedge clkin);
        reset = 1'b1;
        c = 0;
        while (c < 17) begin
            step();
            slot = ((c - 1) / 4) % 4;
            vectors++;
            if (bus.anode !== exp_anode(slot)) begin
                miscompares++;
                $display("FAIL restart_anode c=%0d got %b want %b", c, bus.anode, exp_anode(slot));
            end
            vectors++;
            if (bus.Digit !== idle_digit(slot)) begin
                miscompares++;
                $display("FAIL restart_digit c=%0d got %h want %h", c, bus.Digit, idle_digit(slot));
            end
            vectors++;
            if (bus.pending !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_pending c=%0d got %b want 0", c, bus.pending);
            end
            vectors++;
            if (bus.frame_done !== (c == 16)) begin
                miscompares++;
                $display("FAIL restart_frame_done c=%0d got %b want %b", c, bus.frame_done, c == 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_load_midframe();
        test_last_write_wins();
        test_load_at_wrap();
        test_blank_mask();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
